// File: rtl/gray_decode_pipe.sv
// Two-stage pipelined Gray-to-binary decoder with valid/ready handshake,
// step checking (0 or +1 mod 2^W) and a saturating violation counter.
module gray_decode_pipe #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_bin,
    output logic             out_step_err,
    input  logic             clr,
    output logic [CNT_W-1:0] err_cnt
);

    logic         en;
    logic         load;
    logic         s1_valid;
    logic [W-1:0] s1_gray;
    logic [W-1:0] dec;
    logic         acc;
    logic         have_prev;
    logic [W-1:0] prev;
    logic [W-1:0] delta;
    logic         step_err;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign load     = en && s1_valid;

    // Running XOR from the MSB down yields each binary bit.
    always_comb begin
        dec = '0;
        acc = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            acc            = acc ^ s1_gray[W-1-i];
            dec[W-1-i]     = acc;
        end
    end

    // A clr in the load cycle makes this beat a fresh first beat.
    always_comb begin
        delta    = dec - prev;
        step_err = have_prev && !clr && (delta[W-1:1] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_gray      <= '0;
            out_valid    <= 1'b0;
            out_bin      <= '0;
            out_step_err <= 1'b0;
            have_prev    <= 1'b0;
            prev         <= '0;
            err_cnt      <= '0;
        end else begin
            if (en) begin
                s1_valid     <= in_valid;
                s1_gray      <= in_gray;
                out_valid    <= s1_valid;
                out_bin      <= dec;
                out_step_err <= load && step_err;
            end

            if (load) begin
                prev      <= dec;
                have_prev <= 1'b1;
            end else if (clr) begin
                have_prev <= 1'b0;
            end

            if (clr) begin
                err_cnt <= '0;
            end else if (load && step_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gray_decode_pipe.sv
// Bench for gray_decode_pipe (W=4, CNT_W=2): directed vector table plus
// randomized handshake traffic checked against a transaction-level model.
module tb_gray_decode_pipe;

    localparam int W     = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_gray = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_bin;
    logic             out_step_err;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    gray_decode_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_gray     (in_gray),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bin     (out_bin),
        .out_step_err(out_step_err),
        .clr         (clr),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
        logic       err;
        logic [1:0] cnt;
        logic       clr;   // assert clr in the cycle this beat loads into S2
    } vec_t;

    typedef struct {
        int bin;
        int err;
        int cnt;
    } exp_t;

    vec_t       vec[19];
    exp_t       expq[$];
    logic [3:0] gq[$];
    int         m_have, m_prev, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int g2b(input logic [3:0] g);
        int b;
        b = int'(g);
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        return b & 15;
    endfunction

    function automatic logic [3:0] b2g(input int v);
        int t;
        t = (v ^ (v >> 1)) & 15;
        return t[3:0];
    endfunction

    task automatic model_clear();
        m_have = 0;
        m_prev = 0;
        m_cnt  = 0;
    endtask

    task automatic model_accept(input logic [3:0] g);
        exp_t e;
        int   b;
        int   d;
        b     = g2b(g);
        e.err = 0;
        if (m_have != 0) begin
            d     = (b - m_prev) & 15;
            e.err = (d != 0 && d != 1) ? 1 : 0;
        end
        m_have = 1;
        m_prev = b;
        if (e.err != 0 && m_cnt < 3) m_cnt++;
        e.bin = b;
        e.cnt = m_cnt;
        expq.push_back(e);
    endtask

    task automatic clr_pulse();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_cnt", err_cnt, 0);
    endtask

    // Streams vec[lo..hi] back to back; vec[c-1] sits in S2 after the edge of iteration c.
    task automatic run_group(input int lo, input int hi);
        out_ready = 1'b1;
        for (int c = lo; c <= hi + 1; c++) begin
            if (c <= hi) begin
                in_valid = 1'b1;
                in_gray  = vec[c].gray;
            end else begin
                in_valid = 1'b0;
            end
            clr = (c > lo) && vec[c-1].clr;
            @(posedge clk); #1;
            if (c > lo) begin
                chk($sformatf("v%0d_valid", c-1), out_valid, 1);
                chk($sformatf("v%0d_bin", c-1), out_bin, vec[c-1].bin);
                chk($sformatf("v%0d_err", c-1), out_step_err, vec[c-1].err);
                chk($sformatf("v%0d_cnt", c-1), err_cnt, vec[c-1].cnt);
            end
        end
        clr      = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    // Handshake-driven stream of gq; bp=1 applies a fixed 3-cycle output stall.
    task automatic stream(input int max_cycles, input bit bp);
        bit         held;
        bit         done;
        logic [3:0] hb;
        logic       hs;
        logic [1:0] hc;
        exp_t       e;
        held = 1'b0;
        done = 1'b0;
        hb   = '0;
        hs   = 1'b0;
        hc   = '0;
        for (int cyc = 0; cyc < max_cycles && !done; cyc++) begin
            in_valid  = (gq.size() > 0) && (bp || $urandom_range(0, 9) < 7);
            in_gray   = (gq.size() > 0) ? gq[0] : 4'd0;
            out_ready = bp ? !(cyc >= 4 && cyc <= 6) : ($urandom_range(0, 9) < 7);
            #1;
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (bp && cyc >= 4 && cyc <= 6) chk("stall_in_ready", in_ready, 0);
            if (held) begin
                chk("hold_bin", out_bin, hb);
                chk("hold_err", out_step_err, hs);
                chk("hold_cnt", err_cnt, hc);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_beat: got bin %0d expected no beat", out_bin);
                end else begin
                    e = expq.pop_front();
                    chk("s_bin", out_bin, e.bin);
                    chk("s_err", out_step_err, e.err);
                    chk("s_cnt", err_cnt, e.cnt);
                end
            end
            if (in_valid && in_ready) model_accept(gq.pop_front());
            held = out_valid && !out_ready;
            hb   = out_bin;
            hs   = out_step_err;
            hc   = err_cnt;
            @(posedge clk); #1;
            done = (gq.size() == 0) && (expq.size() == 0);
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_timeout: got %0d beats pending expected 0", expq.size() + gq.size());
            gq.delete();
            expq.delete();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;

        vec[0]  = '{4'b0110, 4'd4,  1'b0, 2'd0, 1'b0};
        vec[1]  = '{4'b1111, 4'd10, 1'b1, 2'd1, 1'b0};
        vec[2]  = '{4'b1001, 4'd14, 1'b0, 2'd0, 1'b0};
        vec[3]  = '{4'b1000, 4'd15, 1'b0, 2'd0, 1'b0};
        vec[4]  = '{4'b0000, 4'd0,  1'b0, 2'd0, 1'b0};
        vec[5]  = '{4'b0000, 4'd0,  1'b0, 2'd0, 1'b0};
        vec[6]  = '{4'b0001, 4'd1,  1'b0, 2'd0, 1'b0};
        vec[7]  = '{4'b0000, 4'd0,  1'b0, 2'd0, 1'b0};
        vec[8]  = '{4'b1100, 4'd8,  1'b1, 2'd1, 1'b0};
        vec[9]  = '{4'b0000, 4'd0,  1'b1, 2'd2, 1'b0};
        vec[10] = '{4'b1100, 4'd8,  1'b1, 2'd3, 1'b0};
        vec[11] = '{4'b0000, 4'd0,  1'b1, 2'd3, 1'b0};
        vec[12] = '{4'b1100, 4'd8,  1'b1, 2'd3, 1'b0};
        vec[13] = '{4'b0010, 4'd3,  1'b0, 2'd0, 1'b0};
        vec[14] = '{4'b1101, 4'd9,  1'b1, 2'd1, 1'b0};
        vec[15] = '{4'b0000, 4'd0,  1'b0, 2'd0, 1'b1};
        vec[16] = '{4'b0001, 4'd1,  1'b0, 2'd0, 1'b0};
        vec[17] = '{4'b0100, 4'd7,  1'b0, 2'd0, 1'b0};
        vec[18] = '{4'b1010, 4'd12, 1'b1, 2'd1, 1'b0};

        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bin", out_bin, 0);
        chk("rst_step_err", out_step_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_group(0, 1);
        clr_pulse();
        run_group(2, 6);
        clr_pulse();
        run_group(7, 12);
        clr_pulse();
        run_group(13, 16);

        clr_pulse();
        model_clear();
        for (int i = 0; i < 6; i++) gq.push_back(b2g(i));
        stream(60, 1'b1);

        for (int k = 0; k < 6; k++) begin
            clr_pulse();
            model_clear();
            v = $urandom_range(0, 15);
            for (int i = 0; i < 30; i++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2:    v = v;
                    3, 4, 5, 6: v = (v + 1) & 15;
                    default:    v = $urandom_range(0, 15);
                endcase
                gq.push_back(b2g(v));
            end
            stream(600, 1'b0);
        end

        clr_pulse();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_gray   = 4'b0000;
        @(posedge clk); #1;
        in_gray = 4'b0111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_valid", out_valid, 1);
        chk("mid_bin", out_bin, 5);
        chk("mid_err", out_step_err, 1);
        chk("mid_cnt", err_cnt, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_bin", out_bin, 0);
        chk("arst_cnt", err_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", out_valid, 0);
        run_group(17, 18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
